// File: rtl/reg_file_scoreboard_if.sv
// Issue, operand and writeback signal bundle for reg_file_scoreboard.
// master = decoder/execute/writeback side, slave = register file.
interface reg_file_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            iss_valid;
    logic            iss_ready;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            rd_wen;

    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [AW-1:0]   op_rd;
    logic            op_rd_wen;

    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        output iss_valid, rs1, rs2, rd, rd_wen, op_ready, wb_valid, wb_rd, wb_data,
        input  iss_ready, op_valid, rs1_data, rs2_data, op_rd, op_rd_wen
    );

    modport slave (
        input  iss_valid, rs1, rs2, rd, rd_wen, op_ready, wb_valid, wb_rd, wb_data,
        output iss_ready, op_valid, rs1_data, rs2_data, op_rd, op_rd_wen
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Integer register file with per-register busy scoreboard and a one-entry operand register.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle writeback data to stalled sources.
module reg_file_scoreboard #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_file_scoreboard_if.slave bus
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    logic            wb_hit;
    logic [XLEN-1:0] rd1_val;
    logic [XLEN-1:0] rd2_val;
    logic            busy1;
    logic            busy2;
    logic            src_haz;
    logic            waw_haz;
    logic            slot_free;
    logic            accept;

    logic            op_valid_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [AW-1:0]   op_rd_q;
    logic            op_rd_wen_q;

    assign wb_hit = bus.wb_valid && (bus.wb_rd != '0);

`ifdef REGFILE_WB_BYPASS_EN
    logic byp1;
    logic byp2;

    assign byp1 = wb_hit && (bus.wb_rd == bus.rs1);
    assign byp2 = wb_hit && (bus.wb_rd == bus.rs2);

    always_comb begin
        rd1_val = '0;
        rd2_val = '0;
        if (bus.rs1 != '0) rd1_val = byp1 ? bus.wb_data : mem[bus.rs1];
        if (bus.rs2 != '0) rd2_val = byp2 ? bus.wb_data : mem[bus.rs2];
    end

    // A source being written back this cycle is satisfied by the forwarded data.
    assign busy1 = (bus.rs1 != '0) && busy[bus.rs1] && !byp1;
    assign busy2 = (bus.rs2 != '0) && busy[bus.rs2] && !byp2;
`else
    always_comb begin
        rd1_val = '0;
        rd2_val = '0;
        if (bus.rs1 != '0) rd1_val = mem[bus.rs1];
        if (bus.rs2 != '0) rd2_val = mem[bus.rs2];
    end

    assign busy1 = (bus.rs1 != '0) && busy[bus.rs1];
    assign busy2 = (bus.rs2 != '0) && busy[bus.rs2];
`endif

    assign src_haz   = busy1 || busy2;
    assign waw_haz   = bus.rd_wen && (bus.rd != '0) && busy[bus.rd];
    assign slot_free = !op_valid_q || bus.op_ready;
    assign accept    = bus.iss_valid && bus.iss_ready;

    assign bus.iss_ready = slot_free && !src_haz && !waw_haz;

    // Clear on writeback first, then set on accept so a new producer keeps ownership.
    always_comb begin
        busy_nxt = busy;
        if (wb_hit) busy_nxt[bus.wb_rd] = 1'b0;
        if (accept && bus.rd_wen && (bus.rd != '0)) busy_nxt[bus.rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wb_hit) begin
            mem[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q  <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            op_rd_q     <= '0;
            op_rd_wen_q <= 1'b0;
        end else if (accept) begin
            op_valid_q  <= 1'b1;
            rs1_data_q  <= rd1_val;
            rs2_data_q  <= rd2_val;
            op_rd_q     <= bus.rd;
            op_rd_wen_q <= bus.rd_wen;
        end else if (bus.op_ready) begin
            op_valid_q  <= 1'b0;
        end
    end

    assign bus.op_valid  = op_valid_q;
    assign bus.rs1_data  = rs1_data_q;
    assign bus.rs2_data  = rs2_data_q;
    assign bus.op_rd     = op_rd_q;
    assign bus.op_rd_wen = op_rd_wen_q;

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Integer register file with a per-register busy scoreboard. It sits directly downstream of the register address decoder and consumes its rs1/rs2/rd indices. For each issued instruction it reads both source operands, stalls issue while any source or the destination has a pending write, and hands the operands to the execute stage through a one-entry valid/ready output register. Writeback from the later pipeline stages updates the array and clears the busy bits.

Parameters:
XLEN, 32, data width of each register
AW, 5, register index width; matches `rs1_width / `rs2_width / `rd_width
NREG, 32, number of architectural registers (2**AW)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
iss_valid  input  1  decoder presents an instruction
iss_ready  output  1  block accepts the instruction this cycle
rs1  input  AW  source 1 index
rs2  input  AW  source 2 index
rd  input  AW  destination index
rd_wen  input  1  instruction will write rd
op_valid  output  1  operand register holds valid data
op_ready  input  1  execute stage consumes operands
rs1_data  output  XLEN  source 1 operand
rs2_data  output  XLEN  source 2 operand
op_rd  output  AW  destination index forwarded with the operands
op_rd_wen  output  1  rd_wen forwarded with the operands
wb_valid  input  1  writeback strobe
wb_rd  input  AW  writeback index
wb_data  input  XLEN  writeback data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all array entries 0, busy[] all 0, op_valid 0, rs1_data/rs2_data 0, op_rd 0, op_rd_wen 0.
- x0 handling: x0 always reads 0. Writes to x0 are dropped. busy[0] is never set.
- Hazards:
  - src_haz = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2])
  - waw_haz = rd_wen && rd!=0 && busy[rd]
- Output slot free: slot_free = !op_valid || op_ready.
- iss_ready = slot_free && !src_haz && !waw_haz. It is combinational and does not depend on iss_valid.
- Accept (iss_valid && iss_ready):
  - Next edge: rs1_data/rs2_data load the array contents, op_rd/op_rd_wen load rd/rd_wen, op_valid=1.
  - If rd_wen && rd!=0, set busy[rd].
  - Latency is 1 cycle from accept to op_valid.
- Hold: while op_valid && !op_ready, all op_* outputs remain stable.
- Drain: op_ready with no accept in the same cycle -> op_valid=0 on the next edge.
- Writeback: wb_valid && wb_rd!=0 writes array[wb_rd]=wb_data and clears busy[wb_rd] on the next edge. Writeback to a non-busy register still writes; no error is raised.
- Same-cycle writeback and accept setting the same busy bit: the set wins (new producer owns the register).
- Same-cycle writeback to a source register of a stalled instruction: without the bypass, the stall holds this cycle and the instruction issues the next cycle with the new value.
- Array reads return pre-writeback contents within a cycle unless the bypass below is enabled.
- Reset mid-operation: all state clears immediately. An in-flight op_valid drops asynchronously and busy bits clear.

Optional Feature:
Macro REGFILE_WB_BYPASS_EN.
- Defined:
  - A source matching wb_rd (nonzero) while wb_valid is not counted as busy.
  - Its operand is taken from wb_data, so an instruction stalled on a writeback issues in that same cycle.
- Undefined: no bypass; the instruction issues one cycle after the writeback.
- Both builds must pass every other test unchanged.

Test Plan:
- Reset, then read all 32 registers -> every rs1_data/rs2_data = 0, op_valid 0 out of reset.
- wb x5=0xDEADBEEF, then issue rs1=5, rs2=0 -> one cycle later op_valid=1, rs1_data=0xDEADBEEF, rs2_data=0.
- Issue rd=7 with rd_wen, then issue rs1=7 -> iss_ready=0 until wb x7=0x1234.
  - Bypass off: issues the following cycle with rs1_data=0x1234.
  - Bypass on: issues in the writeback cycle with rs1_data=0x1234.
- wb x0=0xFFFFFFFF, then issue rs1=0 -> rs1_data=0. Issue rd=0 with rd_wen, then issue rs1=0 -> no stall.
- Hold op_ready=0 for 3 cycles after an accept -> outputs stable, iss_ready=0. Raise op_ready with iss_valid -> back-to-back accept, op_valid stays 1.
- Set busy[9]. Same cycle: wb x9 plus issue a new rd=9 (WAW stall) -> stall for that cycle; the next cycle it accepts and busy[9]=1. Assert rst_n=0 mid-stall -> op_valid=0 and busy cleared immediately.
